rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares one single-port synchronous instruction/data ROM between the CPU instruction-fetch port and the data-load port. Requests are arbitrated every cycle and issued to the ROM back-to-back. Read data is returned to the winning requester through a registered response stage with a fixed latency. The block sits between the core's two memory ports and the ROM's `addr`/`q` pins.

## Interface
- `ADDRESS_WIDTH`, 16: byte-address width; word address is `[ADDRESS_WIDTH-1:2]`.
- `DATA_WIDTH`, 32: ROM word width.

- `clk` in 1: sole clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request; held with `i_addr` until accepted.
- `i_addr` in `[ADDRESS_WIDTH-1:2]`: fetch word address.
- `i_ready` out 1: fetch accepted this cycle (combinational).
- `i_valid` out 1: one-cycle pulse, `i_data` valid.
- `i_data` out DATA_WIDTH: fetch read data, held until next fetch response.
- `d_req`, `d_addr`, `d_ready`, `d_valid`, `d_data`: data-port equivalents.
- `rom_addr` out `[ADDRESS_WIDTH-1:2]`: ROM word address.
- `rom_q` in DATA_WIDTH: ROM registered output, valid one cycle after `rom_addr`.

## Operation
- Accept = `x_req & x_ready`. At most one port is accepted per cycle, and a port may be accepted every cycle.
- Grant:
  - Only one port requesting: that port is granted.
  - Both requesting: tie rule (see Configuration).
  - Neither requesting: no grant.
- `x_ready` is high only for the granted port. It depends on `i_req`/`d_req` and `last_grant` only, never on `rom_q`.
- `rom_addr` is the granted port's address. With no grant it holds the last issued address; reset value 0.
- Stage 1 registers `s1_valid` and `s1_port` at the accept edge.
- Stage 2: when `s1_valid`, load `rom_q` into the port's data register and pulse its `x_valid`. The other port's data and valid are untouched.
- There is no response backpressure. Requesters must take `x_valid` when it occurs.
- `last_grant` updates only on an accept.
- Reset values: `i_valid`, `d_valid`, `s1_valid` = 0; `i_data`, `d_data`, `rom_addr` = 0; `last_grant` = FETCH.
- Reset asserted mid-operation flushes both stages. No `x_valid` is produced after release for requests accepted before reset.
- A port may change its address after acceptance. The data returned is always for the address at the accept edge.

## Timing
- Accept in cycle N: `rom_addr` is driven in N, `rom_q` is valid in N+1, and `x_valid`/`x_data` are registered and high in N+2.
- Latency is fixed at 2 cycles. Throughput is 1 word/cycle aggregate.
- Both ports requesting continuously (round-robin build): grants alternate every cycle, and each port receives one response every 2 cycles.
- Fetch and data responses never pulse `x_valid` in the same cycle.

## Configuration
- `ROM_ARB_ROUND_ROBIN_EN` defined: on a tie, grant the port that did not win the last accept. After reset the first tie goes to DATA.
- Not defined: fixed priority, DATA always wins ties. `last_grant` is still maintained but is unused by the tie rule. Fetch can starve while `d_req` is held high.

## Structure
- Package `rom_arb_pkg`:
  - `port_t` enum: `PORT_FETCH=0`, `PORT_DATA=1`.
  - `LATENCY` localparam = 2.
- Sub-module `rom_arb_pick` (combinational): inputs `i_req`, `d_req`, `last_grant`; outputs `grant_valid`, `grant_port`. It holds the only `ROM_ARB_ROUND_ROBIN_EN` branch.
- Top-level `rom_arbiter`: `rom_addr` mux, hold register, stage-1/stage-2 pipeline registers.

## Test plan
- Single fetch: ROM[5]=0xDEADBEEF, `i_req`/`i_addr`=5 for one cycle. Expect `i_ready` in N; `i_valid`=1 and `i_data`=0xDEADBEEF in N+2; `d_valid` stays 0.
- Streaming fetch at addrs 0,1,2,3 on consecutive cycles: 4 consecutive `i_valid` pulses starting N+2 with ROM[0..3] in order.
- Tie, round-robin build: both ports held for 4 cycles. Grants go D,F,D,F; `d_data`/`i_data` match their addresses.
- Tie, fixed build: both held 4 cycles. All 4 grants go to D and `i_ready` stays 0.
- Reset mid-flight: accept fetch at N, assert `rst_n`=0 in N+1, release in N+3. Expect no `i_valid`, `i_data`=0, `rom_addr`=0.
- Address change after accept: `d_addr` goes 7→9 the cycle after accept. `d_data` returns ROM[7].

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for the ROM arbiter
package rom_arb_pkg;

    // Requester identity; also the encoding of last_grant.
    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // Cycles from accept to x_valid (one ROM cycle + one response register).
    localparam int LATENCY = 2;

endpackage

// File: rtl/rom_arb_pick.sv
// rtl/rom_arb_pick.sv - combinational grant selection for the ROM arbiter
//
// Ports:
//   i_req, d_req  - fetch / data port requests
//   last_grant    - port that won the most recent accept
//   grant_valid   - some port is granted this cycle
//   grant_port    - which port is granted (meaningful when grant_valid)
//
// Build option: ROM_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the port that did not win the last accept
//   undefined - ties always go to DATA; last_grant is ignored
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant_port
);

`ifndef ROM_ARB_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_valid = i_req | d_req;
        grant_port  = PORT_FETCH;
        if (d_req && !i_req) begin
            grant_port = PORT_DATA;
        end else if (d_req && i_req) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            grant_port = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
`else
            grant_port = PORT_DATA;
`endif
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares one synchronous ROM between fetch and data ports
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   i_req, i_addr         - fetch request and word address (held until i_ready)
//   i_ready               - fetch accepted this cycle (combinational)
//   i_valid, i_data       - fetch response pulse and held read data
//   d_req, d_addr         - data-load request and word address
//   d_ready               - data accepted this cycle (combinational)
//   d_valid, d_data       - data response pulse and held read data
//   rom_addr              - ROM word address
//   rom_q                 - ROM registered read data (one cycle after rom_addr)
//
// Build option: ROM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (see rom_arb_pick); default is DATA-wins fixed priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [ADDRESS_WIDTH-1:2] i_addr,
    output logic                     i_ready,
    output logic                     i_valid,
    output logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     d_req,
    input  logic [ADDRESS_WIDTH-1:2] d_addr,
    output logic                     d_ready,
    output logic                     d_valid,
    output logic [DATA_WIDTH-1:0]    d_data,
    output logic [ADDRESS_WIDTH-1:2] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_q
);

    logic                     grant_valid;
    port_t                    grant_port;
    port_t                    last_grant;
    logic                     accept;
    logic [ADDRESS_WIDTH-1:2] addr_hold;
    logic                     s1_valid;
    port_t                    s1_port;

    rom_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Ready is a pure function of the requests and last_grant, so a requester
    // never sees a combinational path from rom_q.
    assign i_ready = grant_valid && (grant_port == PORT_FETCH);
    assign d_ready = grant_valid && (grant_port == PORT_DATA);
    assign accept  = (i_req && i_ready) || (d_req && d_ready);

    // The address is captured by the ROM at the accept edge, so later
    // address changes on the port cannot affect the returned word. On idle
    // cycles the last issued address is replayed to keep the ROM pins quiet.
    always_comb begin
        rom_addr = addr_hold;
        if (grant_valid) begin
            rom_addr = (grant_port == PORT_DATA) ? d_addr : i_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold  <= '0;
            last_grant <= PORT_FETCH;
            s1_valid   <= 1'b0;
            s1_port    <= PORT_FETCH;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            i_data     <= '0;
            d_data     <= '0;
        end else begin
            if (accept) begin
                addr_hold  <= rom_addr;
                last_grant <= grant_port;
            end

            // Stage 1 tracks the request while the ROM is reading it.
            s1_valid <= accept;
            s1_port  <= grant_port;

            // Stage 2 steers rom_q to the owning port; the other port keeps
            // its previous data.
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_port == PORT_DATA) begin
                    d_data  <= rom_q;
                    d_valid <= 1'b1;
                end else begin
                    i_data  <= rom_q;
                    i_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
module tb_rom_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:2] i_addr = '0;
    logic          i_ready;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          d_req = 1'b0;
    logic [AW-1:2] d_addr = '0;
    logic          d_ready;
    logic          d_valid;
    logic [DW-1:0] d_data;
    logic [AW-1:2] rom_addr;
    logic [DW-1:0] rom_q;

    logic [DW-1:0] rom [WORDS];

    always #5 clk = ~clk;

    // Synchronous ROM: output registered one cycle after the address.
    always_ff @(posedge clk) rom_q <= rom[rom_addr];

    rom_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_ready  (d_ready),
        .d_valid  (d_valid),
        .d_data   (d_data),
        .rom_addr (rom_addr),
        .rom_q    (rom_q)
    );

    // Reference model: grant codes 0 = none, 1 = fetch, 2 = data.
    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    typedef struct {
        logic          ir;
        logic [AW-1:2] ia;
        logic          dr;
        logic [AW-1:2] da;
        int            g_rr;
        int            g_fx;
        logic [AW-1:2] rom_rr;
        logic [AW-1:2] rom_fx;
    } vec_t;

    resp_t         q[$];
    vec_t          vt[17];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_last = 1;
    logic [AW-1:2] m_hold = '0;
    logic [DW-1:0] m_idata = '0;
    logic [DW-1:0] m_ddata = '0;
    int            g_obs = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last  = 1;
        m_hold  = '0;
        m_idata = '0;
        m_ddata = '0;
    endtask

    function automatic int model_pick(input logic ir, input logic dr);
        if (!ir && !dr) return 0;
        if (ir && !dr) return 1;
        if (dr && !ir) return 2;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        return 3 - m_last;
`else
        return 2;
`endif
    endfunction

    // Drive one cycle of requests, check the combinational side, advance the
    // clock and check the registered responses against the scoreboard.
    task automatic step(input logic ir, input logic [AW-1:2] ia,
                        input logic dr, input logic [AW-1:2] da);
        int            g;
        logic [AW-1:2] ea;
        logic          iv;
        logic          dv;
        resp_t         r;
        i_req  = ir;
        i_addr = ia;
        d_req  = dr;
        d_addr = da;
        #1;
        g  = model_pick(ir, dr);
        ea = (g == 1) ? ia : (g == 2) ? da : m_hold;
        chk("i_ready", {31'b0, i_ready}, {31'b0, g == 1});
        chk("d_ready", {31'b0, d_ready}, {31'b0, g == 2});
        chk("rom_addr", {18'b0, rom_addr}, {18'b0, ea});
        if (g != 0) begin
            q.push_back('{g, rom[ea], cyc + 2});
            m_hold = ea;
            m_last = g;
        end
        g_obs = g;
        @(posedge clk);
        #1;
        cyc++;
        iv = 1'b0;
        dv = 1'b0;
        while (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.port == 1) begin
                iv = 1'b1;
                m_idata = r.data;
            end else begin
                dv = 1'b1;
                m_ddata = r.data;
            end
        end
        chk("i_valid", {31'b0, i_valid}, {31'b0, iv});
        chk("d_valid", {31'b0, d_valid}, {31'b0, dv});
        chk("i_data", i_data, m_idata);
        chk("d_data", d_data, m_ddata);
        chk("one_pulse", {31'b0, i_valid & d_valid}, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < WORDS; k++) rom[k] = $urandom;
        rom[5] = 32'hDEADBEEF;

        //          ir    ia      dr    da      rr fx rom_rr  rom_fx
        vt[0]  = '{1'b1, 14'd5,  1'b0, 14'd0,  1, 1, 14'd5,  14'd5};
        vt[1]  = '{1'b0, 14'd0,  1'b0, 14'd0,  0, 0, 14'd5,  14'd5};
        vt[2]  = '{1'b0, 14'd0,  1'b0, 14'd0,  0, 0, 14'd5,  14'd5};
        vt[3]  = '{1'b1, 14'd0,  1'b0, 14'd0,  1, 1, 14'd0,  14'd0};
        vt[4]  = '{1'b1, 14'd1,  1'b0, 14'd0,  1, 1, 14'd1,  14'd1};
        vt[5]  = '{1'b1, 14'd2,  1'b0, 14'd0,  1, 1, 14'd2,  14'd2};
        vt[6]  = '{1'b1, 14'd3,  1'b0, 14'd0,  1, 1, 14'd3,  14'd3};
        vt[7]  = '{1'b0, 14'd0,  1'b0, 14'd0,  0, 0, 14'd3,  14'd3};
        vt[8]  = '{1'b0, 14'd0,  1'b0, 14'd0,  0, 0, 14'd3,  14'd3};
        vt[9]  = '{1'b1, 14'd10, 1'b1, 14'd20, 2, 2, 14'd20, 14'd20};
        vt[10] = '{1'b1, 14'd10, 1'b1, 14'd20, 1, 2, 14'd10, 14'd20};
        vt[11] = '{1'b1, 14'd10, 1'b1, 14'd20, 2, 2, 14'd20, 14'd20};
        vt[12] = '{1'b1, 14'd10, 1'b1, 14'd20, 1, 2, 14'd10, 14'd20};
        vt[13] = '{1'b0, 14'd0,  1'b1, 14'd7,  2, 2, 14'd7,  14'd7};
        vt[14] = '{1'b0, 14'd0,  1'b0, 14'd9,  0, 0, 14'd7,  14'd7};
        vt[15] = '{1'b0, 14'd0,  1'b0, 14'd9,  0, 0, 14'd7,  14'd7};
        vt[16] = '{1'b0, 14'd0,  1'b0, 14'd9,  0, 0, 14'd7,  14'd7};

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_valid", {31'b0, i_valid}, 32'd0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst_i_data", i_data, 32'd0);
        chk("rst_d_data", d_data, 32'd0);
        chk("rst_rom_addr", {18'b0, rom_addr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: single fetch, streaming, tie, address change.
        for (int v = 0; v < 17; v++) begin
            step(vt[v].ir, vt[v].ia, vt[v].dr, vt[v].da);
`ifdef ROM_ARB_ROUND_ROBIN_EN
            chk($sformatf("vec%0d_grant", v), g_obs, vt[v].g_rr);
            chk($sformatf("vec%0d_addr", v), {18'b0, m_hold}, {18'b0, vt[v].rom_rr});
`else
            chk($sformatf("vec%0d_grant", v), g_obs, vt[v].g_fx);
            chk($sformatf("vec%0d_addr", v), {18'b0, m_hold}, {18'b0, vt[v].rom_fx});
`endif
            if (v == 1) chk("fetch5_data", i_data, 32'hDEADBEEF);
            if (v == 14) chk("d_addr_change", d_data, rom[7]);
        end

        // Reset while a fetch is in flight.
        step(1'b1, 14'd5, 1'b0, 14'd0);
        rst_n = 1'b0;
        i_req = 1'b0;
        model_reset();
        #1;
        chk("midrst_rom_addr", {18'b0, rom_addr}, 32'd0);
        chk("midrst_i_data", i_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 14'd0, 1'b0, 14'd0);
        chk("postrst_i_data", i_data, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 14'($urandom),
                 1'($urandom_range(0, 1)), 14'($urandom));
        end
        for (int k = 0; k < 3; k++) step(1'b0, 14'd0, 1'b0, 14'd0);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
